hazard_controller: RTL and testbench

- Pipeline hazard sequencer for the 5-stage core; sits beside the EX-stage forwarding logic.
- Detects hazards that forwarding cannot cover: load-use, data-memory wait states, multi-cycle mul/div and taken-branch redirects.
- Generates per-stage stall and bubble/flush controls, handles the data-memory wait timeout, and keeps a stall-cycle performance counter.

---
 rtl/hazard_controller.sv | 142 ++++++++++++++
 tb/tb_hazard_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use, data-memory wait, mul/div and branch-redirect
// stall/bubble/flush generation, plus wait-timeout handling and a stall-cycle counter.
module hazard_controller #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       idex_rd,
    input  logic             idex_memread,
    input  logic             idex_wb,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ack_i,
    input  logic             muldiv_start_EX,
    input  logic             muldiv_done_i,
    input  logic             branch_taken_EX,
    output logic             stall_IF_o,
    output logic             stall_ID_o,
    output logic             stall_EX_o,
    output logic             stall_MEM_o,
    output logic             bubble_EX_o,
    output logic             bubble_MEM_o,
    output logic             flush_IF_o,
    output logic             dmem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned WAIT_W     = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned WAIT_LAST  = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_ERR     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               md_busy_q, md_busy_d;

    logic mem_hold;
    logic md_hold;
    logic load_use;

    // Hazard terms; ERR forces the memory hold off so the pipeline advances as if acked
    assign mem_hold = dmem_req_MEM & ~dmem_ack_i & (state_q != ST_ERR);
    assign md_hold  = (md_busy_q | muldiv_start_EX) & ~muldiv_done_i;
    assign load_use = idex_memread & ~idex_wb & (idex_rd != 5'd0)
                    & ((rs1_used_ID & (rs1_ID == idex_rd))
                     | (rs2_used_ID & (rs2_ID == idex_rd)));

    assign md_busy_d = muldiv_done_i ? 1'b0 : (muldiv_start_EX ? 1'b1 : md_busy_q);

    // State register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            md_busy_q <= md_busy_d;
        end
    end

    // Next state; an ack on the limit cycle takes precedence over the timeout
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            ST_RUN: begin
                if (dmem_req_MEM && !dmem_ack_i) begin
                    state_d = ST_MEMWAIT;
                end
            end
            ST_MEMWAIT: begin
                if (dmem_ack_i) begin
                    state_d = ST_RUN;
                end else if (TIMEOUT_EN && (wait_q == WAIT_W'(WAIT_LAST))) begin
                    state_d = ST_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Mealy pipeline controls, one priority row active at a time
    always_comb begin
        stall_IF_o   = 1'b0;
        stall_ID_o   = 1'b0;
        stall_EX_o   = 1'b0;
        stall_MEM_o  = 1'b0;
        bubble_EX_o  = 1'b0;
        bubble_MEM_o = 1'b0;
        flush_IF_o   = 1'b0;
        dmem_err_o   = 1'b0;
        if (reset_i) begin
            if (mem_hold) begin
                stall_IF_o  = 1'b1;
                stall_ID_o  = 1'b1;
                stall_EX_o  = 1'b1;
                stall_MEM_o = 1'b1;
            end else if (md_hold) begin
                stall_IF_o   = 1'b1;
                stall_ID_o   = 1'b1;
                stall_EX_o   = 1'b1;
                bubble_MEM_o = 1'b1;
            end else if (branch_taken_EX) begin
                flush_IF_o  = 1'b1;
                bubble_EX_o = 1'b1;
            end else if (load_use) begin
                stall_IF_o  = 1'b1;
                stall_ID_o  = 1'b1;
                bubble_EX_o = 1'b1;
            end
            dmem_err_o = (state_q == ST_ERR);
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_cnt_o <= '0;
        end else if (stall_IF_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table, directed corner sequences
// and random stimulus against a cycle-level reference model.
module tb_hazard_controller;

    localparam int unsigned TO      = 4;
    localparam int unsigned CW      = 4;
    localparam int          CNT_MAX = 15;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       wb;
        logic       req;
        logic       ack;
        logic       ms;
        logic       md;
        logic       br;
    } in_t;

    typedef struct {
        in_t        v;
        logic [7:0] exp;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [4:0]    rs1_ID, rs2_ID, idex_rd;
    logic          rs1_used_ID, rs2_used_ID, idex_memread, idex_wb;
    logic          dmem_req_MEM, dmem_ack_i, muldiv_start_EX, muldiv_done_i, branch_taken_EX;
    logic          stall_IF_o, stall_ID_o, stall_EX_o, stall_MEM_o;
    logic          bubble_EX_o, bubble_MEM_o, flush_IF_o, dmem_err_o;
    logic [CW-1:0] stall_cnt_o;
    logic [7:0]    outs;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles already spent waiting on memory, error cycle pending
    bit m_waiting, m_err, m_md;
    int m_waited, m_cnt;

    hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .idex_rd(idex_rd), .idex_memread(idex_memread), .idex_wb(idex_wb),
        .dmem_req_MEM(dmem_req_MEM), .dmem_ack_i(dmem_ack_i),
        .muldiv_start_EX(muldiv_start_EX), .muldiv_done_i(muldiv_done_i),
        .branch_taken_EX(branch_taken_EX),
        .stall_IF_o(stall_IF_o), .stall_ID_o(stall_ID_o),
        .stall_EX_o(stall_EX_o), .stall_MEM_o(stall_MEM_o),
        .bubble_EX_o(bubble_EX_o), .bubble_MEM_o(bubble_MEM_o),
        .flush_IF_o(flush_IF_o), .dmem_err_o(dmem_err_o),
        .stall_cnt_o(stall_cnt_o)
    );

    assign outs = {stall_IF_o, stall_ID_o, stall_EX_o, stall_MEM_o,
                   bubble_EX_o, bubble_MEM_o, flush_IF_o, dmem_err_o};

    always #5 clk_i = ~clk_i;

    function automatic in_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                               input int rd, input bit mr, input bit wb, input bit req,
                               input bit ack, input bit ms, input bit md, input bit br);
        in_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2; v.rd = 5'(rd);
        v.mr = mr; v.wb = wb; v.req = req; v.ack = ack; v.ms = ms; v.md = md; v.br = br;
        return v;
    endfunction

    task automatic drive(input in_t v);
        rs1_ID = v.rs1; rs2_ID = v.rs2; rs1_used_ID = v.u1; rs2_used_ID = v.u2;
        idex_rd = v.rd; idex_memread = v.mr; idex_wb = v.wb;
        dmem_req_MEM = v.req; dmem_ack_i = v.ack;
        muldiv_start_EX = v.ms; muldiv_done_i = v.md; branch_taken_EX = v.br;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Output bit order: stall IF,ID,EX,MEM, bubble EX,MEM, flush IF, dmem_err
    function automatic logic [7:0] model_out(input in_t v);
        bit         mem, mdh, lu;
        logic [7:0] row;
        mem = v.req && !v.ack && !m_err;
        mdh = (m_md || v.ms) && !v.md;
        lu  = v.mr && !v.wb && (v.rd != 0)
              && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        if (mem)       row = 8'hF0;
        else if (mdh)  row = 8'hE4;
        else if (v.br) row = 8'h0A;
        else if (lu)   row = 8'hC8;
        else           row = 8'h00;
        return row | {7'b0, m_err};
    endfunction

    task automatic model_step(input in_t v, input logic [7:0] o);
        if (o[7] && m_cnt < CNT_MAX) m_cnt++;
        m_md = v.md ? 1'b0 : (v.ms ? 1'b1 : m_md);
        if (m_err) begin
            m_err = 1'b0;
        end else if (m_waiting) begin
            if (v.ack) begin
                m_waiting = 1'b0;
            end else if (TO != 0 && m_waited + 1 == TO) begin
                m_waiting = 1'b0;
                m_err     = 1'b1;
            end else begin
                m_waited++;
            end
        end else if (v.req && !v.ack) begin
            m_waiting = 1'b1;
            m_waited  = 0;
        end
    endtask

    task automatic model_clear();
        m_waiting = 1'b0; m_err = 1'b0; m_md = 1'b0; m_waited = 0; m_cnt = 0;
    endtask

    // One clock: drive at negedge, compare settled outputs, then advance the model
    task automatic cycle(input in_t v, output logic [7:0] got);
        logic [7:0] exp;
        @(negedge clk_i);
        drive(v);
        #1;
        exp = model_out(v);
        got = outs;
        chk("model_outs", 32'(got), 32'(exp));
        chk("model_cnt", 32'(stall_cnt_o), 32'(m_cnt));
        @(posedge clk_i);
        model_step(v, exp);
    endtask

    task automatic do_reset(input in_t v);
        @(negedge clk_i);
        drive(v);
        reset_i = 1'b0;
        #1;
        chk("reset_outs", 32'(outs), 32'h0);
        chk("reset_cnt", 32'(stall_cnt_o), 32'h0);
        model_clear();
        @(negedge clk_i);
        drive(mk(0,0,0,0,0,0,1,0,0,0,0,0));
        reset_i = 1'b1;
    endtask

    vec_t       tab[14];
    in_t        IDLE, REQ, REQACK, ACK, MS, DONE, BUSY, RECOV, v;
    logic [7:0] got;

    initial begin
        IDLE   = mk(0,0,0,0,0,0,1,0,0,0,0,0);
        REQ    = mk(0,0,0,0,0,0,1,1,0,0,0,0);
        REQACK = mk(0,0,0,0,0,0,1,1,1,0,0,0);
        ACK    = mk(0,0,0,0,0,0,1,0,1,0,0,0);
        MS     = mk(0,0,0,0,0,0,1,0,0,1,0,0);
        DONE   = mk(0,0,0,0,0,0,1,0,0,0,1,0);
        BUSY   = IDLE;
        RECOV  = mk(0,0,0,0,0,0,1,0,1,0,1,0);

        tab[0]  = '{mk(5,0,1,0,5,1,0,0,0,0,0,0), 8'hC8};
        tab[1]  = '{mk(1,7,0,1,7,1,0,0,0,0,0,0), 8'hC8};
        tab[2]  = '{mk(0,0,1,1,0,1,0,0,0,0,0,0), 8'h00};
        tab[3]  = '{mk(5,0,1,0,5,1,1,0,0,0,0,0), 8'h00};
        tab[4]  = '{mk(5,0,0,0,5,1,0,0,0,0,0,0), 8'h00};
        tab[5]  = '{mk(5,5,1,1,5,0,0,0,0,0,0,0), 8'h00};
        tab[6]  = '{mk(0,0,0,0,0,0,1,0,0,0,0,1), 8'h0A};
        tab[7]  = '{mk(3,0,1,0,3,1,0,0,0,0,0,1), 8'h0A};
        tab[8]  = '{mk(0,0,0,0,0,0,1,1,0,0,0,0), 8'hF0};
        tab[9]  = '{mk(0,0,0,0,0,0,1,1,1,0,0,0), 8'h00};
        tab[10] = '{mk(3,0,1,0,3,1,0,1,0,1,0,1), 8'hF0};
        tab[11] = '{mk(0,0,0,0,0,0,1,0,0,1,0,1), 8'hE4};
        tab[12] = '{mk(0,0,0,0,0,0,1,0,0,1,1,0), 8'h00};
        tab[13] = '{mk(2,0,1,0,2,1,0,0,0,1,0,0), 8'hE4};

        reset_i = 1'b0;
        drive(IDLE);
        model_clear();
        do_reset(IDLE);

        // Vector table, each followed by a cycle that acks memory and completes mul/div
        foreach (tab[i]) begin
            cycle(tab[i].v, got);
            chk($sformatf("vec%0d", i), 32'(got), 32'(tab[i].exp));
            cycle(RECOV, got);
            chk($sformatf("vec%0d_recover", i), 32'(got), 32'h0);
        end

        // Load-use lasts one cycle; x0 destination never stalls
        do_reset(IDLE);
        cycle(mk(5,0,1,0,5,1,0,0,0,0,0,0), got); chk("lu_hit", 32'(got), 32'hC8);
        cycle(IDLE, got);                          chk("lu_after", 32'(got), 32'h0);
        #1 chk("lu_cnt", 32'(stall_cnt_o), 32'd1);
        cycle(mk(0,0,1,0,0,1,0,0,0,0,0,0), got); chk("lu_x0", 32'(got), 32'h0);

        // Memory wait of three cycles
        do_reset(IDLE);
        for (int i = 0; i < 3; i++) begin
            cycle(REQ, got); chk($sformatf("memwait%0d", i), 32'(got), 32'hF0);
        end
        cycle(REQACK, got); chk("memwait_ack", 32'(got), 32'h0);
        #1 chk("memwait_cnt", 32'(stall_cnt_o), 32'd3);

        // Timeout: entry cycle plus TO waiting cycles, then one error cycle
        do_reset(IDLE);
        for (int i = 0; i < int'(TO) + 1; i++) begin
            cycle(REQ, got); chk($sformatf("to_stall%0d", i), 32'(got), 32'hF0);
        end
        cycle(REQACK, got); chk("to_err", 32'(got), 32'h01);
        cycle(ACK, got);    chk("to_late_ack", 32'(got), 32'h0);
        #1 chk("to_cnt", 32'(stall_cnt_o), 32'd5);

        // Ack on the limit cycle wins over the timeout
        do_reset(IDLE);
        for (int i = 0; i < int'(TO); i++) cycle(REQ, got);
        cycle(REQACK, got); chk("lim_ack", 32'(got), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(IDLE, got); chk($sformatf("lim_noerr%0d", i), 32'(got), 32'h0);
        end

        // Mul/div over six cycles with an overlapping memory wait
        do_reset(IDLE);
        cycle(MS, got);     chk("md_start", 32'(got), 32'hE4);
        cycle(BUSY, got);   chk("md_busy1", 32'(got), 32'hE4);
        cycle(REQ, got);    chk("md_mem1", 32'(got), 32'hF0);
        cycle(REQ, got);    chk("md_mem2", 32'(got), 32'hF0);
        cycle(REQACK, got); chk("md_memack", 32'(got), 32'hE4);
        cycle(BUSY, got);   chk("md_busy2", 32'(got), 32'hE4);
        cycle(DONE, got);   chk("md_done", 32'(got), 32'h0);
        #1 chk("md_cnt", 32'(stall_cnt_o), 32'd6);
        cycle(mk(0,0,0,0,0,0,1,0,0,1,1,0), got); chk("md_same", 32'(got), 32'h0);
        cycle(IDLE, got);                          chk("md_same_after", 32'(got), 32'h0);

        // Branch beats a younger load-use
        cycle(mk(5,0,1,0,5,1,0,0,0,0,0,1), got); chk("br_vs_lu", 32'(got), 32'h0A);

        // Reset while waiting on memory with mul/div pending
        do_reset(IDLE);
        cycle(MS, got);
        cycle(REQ, got);
        cycle(REQ, got);
        do_reset(REQ);
        for (int i = 0; i < int'(TO) + 2; i++) begin
            cycle(IDLE, got); chk($sformatf("post_reset%0d", i), 32'(got), 32'h0);
        end

        // Counter saturation
        do_reset(IDLE);
        cycle(MS, got);
        for (int i = 0; i < 19; i++) cycle(BUSY, got);
        #1 chk("sat_cnt", 32'(stall_cnt_o), 32'd15);
        cycle(DONE, got);

        // Random traffic against the model, with occasional asynchronous reset
        for (int n = 0; n < 1500; n++) begin
            v.rs1 = 5'($urandom_range(0, 3));
            v.rs2 = 5'($urandom_range(0, 3));
            v.u1  = 1'($urandom_range(0, 1));
            v.u2  = 1'($urandom_range(0, 1));
            v.rd  = 5'($urandom_range(0, 3));
            v.mr  = 1'($urandom_range(0, 1));
            v.wb  = ($urandom_range(0, 3) == 0);
            v.req = ($urandom_range(0, 2) == 0);
            v.ack = ($urandom_range(0, 3) == 0);
            v.ms  = ($urandom_range(0, 9) == 0);
            v.md  = ($urandom_range(0, 4) == 0);
            v.br  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 255) == 0) do_reset(v);
            else cycle(v, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
